// File: rtl/eeprom_seq_ctrl.sv
// Burst sequencer for the I2C byte-access controller: writes or reads/verifies a run of
// consecutive EEPROM bytes, spacing transactions by a write-cycle gap and guarding each with a timeout.
module eeprom_seq_ctrl #(
  parameter logic [7:0]  BYTE_NUM    = 8'd10,
  parameter logic [15:0] START_ADDR  = 16'h0000,
  parameter logic        ADDR_2B     = 1'b1,
  parameter logic [7:0]  DATA_SEED   = 8'hA0,
  parameter logic [15:0] GAP_WR      = 16'd5000,
  parameter logic [15:0] GAP_RD      = 16'd4,
  parameter logic [15:0] TIMEOUT_MAX = 16'd1000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr_req_i,
  input  logic        rd_req_i,
  input  logic        i2c_end_i,
  input  logic [7:0]  rd_data_i,
  output logic        wr_en_o,
  output logic        rd_en_o,
  output logic        i2c_start_o,
  output logic        addr_num_o,
  output logic [15:0] byte_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  rd_byte_o,
  output logic        rd_byte_vld_o,
  output logic [7:0]  mismatch_cnt_o,
  output logic        err_timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_START, S_WR_WAIT, S_WR_GAP, S_RD_START, S_RD_WAIT, S_RD_GAP, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        err_q, err_d;
  logic [7:0]  mism_q, mism_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic        vld_q, vld_d;

  logic        last_idx;
  logic [7:0]  exp_byte;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // True on the final cycle of a count of lim cycles; a zero limit still takes one cycle.
  function automatic logic reached(input logic [15:0] cnt, input logic [15:0] lim);
    return ({1'b0, cnt} + 17'd1) >= {1'b0, lim};
  endfunction

  assign last_idx = (index_q == BYTE_NUM - 8'd1);
  assign exp_byte = DATA_SEED + index_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
      mism_q    <= '0;
      rd_byte_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
      mism_q    <= mism_d;
      rd_byte_q <= rd_byte_d;
      vld_q     <= vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    rd_pend_d = rd_pend_q;
    err_d     = err_q;
    mism_d    = mism_q;
    rd_byte_d = rd_byte_q;
    vld_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_req_i || rd_req_i) begin
          err_d     = 1'b0;
          index_d   = '0;
          rd_pend_d = rd_req_i;
          if (rd_req_i) mism_d = '0;
          state_d   = wr_req_i ? S_WR_START : S_RD_START;
        end
      end
      S_WR_START: begin
        to_cnt_d = '0;
        state_d  = S_WR_WAIT;
      end
      // Completion wins over a timeout expiring in the same cycle.
      S_WR_WAIT: begin
        if (i2c_end_i) begin
          gap_cnt_d = '0;
          state_d   = S_WR_GAP;
        end else if (reached(to_cnt_q, TIMEOUT_MAX)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_WR_GAP: begin
        if (reached(gap_cnt_q, GAP_WR)) begin
          gap_cnt_d = '0;
          if (last_idx) begin
            index_d = '0;
            state_d = rd_pend_q ? S_RD_START : S_FIN;
          end else begin
            index_d = index_q + 8'd1;
            state_d = S_WR_START;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      S_RD_START: begin
        to_cnt_d = '0;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i2c_end_i) begin
          rd_byte_d = rd_data_i;
          vld_d     = 1'b1;
          if (rd_data_i != exp_byte) mism_d = sat_inc(mism_q);
          gap_cnt_d = '0;
          state_d   = S_RD_GAP;
        end else if (reached(to_cnt_q, TIMEOUT_MAX)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_RD_GAP: begin
        if (reached(gap_cnt_q, GAP_RD)) begin
          gap_cnt_d = '0;
          if (last_idx) begin
            index_d = '0;
            state_d = S_FIN;
          end else begin
            index_d = index_q + 8'd1;
            state_d = S_RD_START;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      S_FIN: begin
        index_d   = '0;
        rd_pend_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address and data are only driven while a transaction is on the bus.
  always_comb begin
    wr_en_o     = 1'b0;
    rd_en_o     = 1'b0;
    i2c_start_o = 1'b0;
    done_o      = 1'b0;
    byte_addr_o = '0;
    wr_data_o   = '0;
    busy_o      = (state_q != S_IDLE);
    addr_num_o  = ADDR_2B;
    case (state_q)
      S_WR_START: begin
        i2c_start_o = 1'b1;
        wr_en_o     = 1'b1;
      end
      S_WR_WAIT: wr_en_o = 1'b1;
      S_RD_START: begin
        i2c_start_o = 1'b1;
        rd_en_o     = 1'b1;
      end
      S_RD_WAIT: rd_en_o = 1'b1;
      S_FIN:     done_o  = 1'b1;
      default: ;
    endcase
    if (wr_en_o || rd_en_o) byte_addr_o = START_ADDR + {8'h00, index_q};
    if (wr_en_o) wr_data_o = DATA_SEED + index_q;
  end

  assign rd_byte_o      = rd_byte_q;
  assign rd_byte_vld_o  = vld_q;
  assign mismatch_cnt_o = mism_q;
  assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_eeprom_seq_ctrl.sv
// Scoreboard bench for eeprom_seq_ctrl: a behavioural I2C controller responds to starts,
// the burst model queues expected starts, read strobes and done pulses, and a monitor checks them.
module tb_eeprom_seq_ctrl;
  localparam logic [7:0]  BN   = 8'd3;
  localparam logic [15:0] SA   = 16'h0010;
  localparam logic [7:0]  SEED = 8'hA0;
  localparam logic [15:0] GW   = 16'd8;
  localparam logic [15:0] GR   = 16'd4;
  localparam logic [15:0] TO   = 16'd50;
  localparam int          NB   = 3;

  logic clk = 1'b0;
  logic rst_n, wr_req, rd_req, i2c_end;
  logic [7:0] rd_data;
  logic wr_en_o, rd_en_o, i2c_start_o, addr_num_o, busy_o, done_o, rd_byte_vld_o, err_timeout_o;
  logic [15:0] byte_addr_o;
  logic [7:0] wr_data_o, rd_byte_o, mismatch_cnt_o;

  eeprom_seq_ctrl #(
    .BYTE_NUM(BN), .START_ADDR(SA), .ADDR_2B(1'b1), .DATA_SEED(SEED),
    .GAP_WR(GW), .GAP_RD(GR), .TIMEOUT_MAX(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wr_req_i(wr_req), .rd_req_i(rd_req),
    .i2c_end_i(i2c_end), .rd_data_i(rd_data),
    .wr_en_o(wr_en_o), .rd_en_o(rd_en_o), .i2c_start_o(i2c_start_o), .addr_num_o(addr_num_o),
    .byte_addr_o(byte_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o),
    .rd_byte_o(rd_byte_o), .rd_byte_vld_o(rd_byte_vld_o), .mismatch_cnt_o(mismatch_cnt_o),
    .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit wr; bit first; logic [15:0] addr; logic [7:0] data; int delta;
  } start_t;
  typedef struct {
    bit err; logic [7:0] mism; bit from_start; int delta;
  } done_t;

  start_t     exp_start[$];
  logic [7:0] exp_vld[$];
  done_t      exp_done[$];

  int req_cyc = 0, last_end_cyc = 0, last_start_cyc = 0;
  int done_cnt = 0, start_cnt = 0;
  logic [15:0] cur_addr = '0;
  int wl[NB];
  int rl[NB];
  logic [7:0] ret[NB];
  bit no_resp = 1'b0;
  logic [7:0] exp_mism = '0;
  int ws = 0, rs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller model: answers each start after the configured latency.
  initial begin
    i2c_end = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!busy_o) begin ws = 0; rs = 0; end
      if (i2c_start_o && !no_resp) begin
        int L;
        logic [7:0] d;
        if (wr_en_o) begin L = wl[ws]; d = 8'h00; ws++; end
        else begin L = rl[rs]; d = ret[rs]; rs++; end
        repeat (L) @(posedge clk);
        #1 i2c_end = 1'b1; rd_data = d;
        @(posedge clk);
        #1 i2c_end = 1'b0; rd_data = 8'($urandom);
      end
    end
  end

  // Monitor: compares every DUT event against the scoreboard queues.
  always @(negedge clk) begin
    if (i2c_end) begin
      last_end_cyc = cyc;
      if (wr_en_o || rd_en_o) chk("addr_hold", 32'(byte_addr_o), 32'(cur_addr));
    end
    if (i2c_start_o) begin
      start_t e;
      start_cnt++;
      last_start_cyc = cyc;
      if (exp_start.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_start: got start at addr %0h, expected none", byte_addr_o);
      end else begin
        e = exp_start.pop_front();
        cur_addr = e.addr;
        chk("start_kind", 32'({wr_en_o, rd_en_o}), e.wr ? 32'd2 : 32'd1);
        chk("start_addr", 32'(byte_addr_o), 32'(e.addr));
        if (e.wr) chk("start_wdata", 32'(wr_data_o), 32'(e.data));
        chk("start_delay", e.first ? 32'(cyc - req_cyc) : 32'(cyc - last_end_cyc), 32'(e.delta));
      end
    end
    if (rd_byte_vld_o) begin
      if (exp_vld.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd_vld: got byte %0h, expected none", rd_byte_o);
      end else begin
        chk("rd_byte", 32'(rd_byte_o), 32'(exp_vld.pop_front()));
      end
    end
    if (done_o) begin
      done_t d;
      done_cnt++;
      if (exp_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done, expected none");
      end else begin
        d = exp_done.pop_front();
        chk("done_err", 32'(err_timeout_o), 32'(d.err));
        chk("done_mismatch_cnt", 32'(mismatch_cnt_o), 32'(d.mism));
        chk("done_delay", d.from_start ? 32'(cyc - last_start_cyc) : 32'(cyc - last_end_cyc),
            32'(d.delta));
      end
    end
  end

  // Burst model: derives every expected event from the request alone.
  task automatic model(input bit w, input bit r);
    start_t s;
    done_t  d;
    int     cnt = 0;
    int     n   = no_resp ? 1 : NB;
    if (w) for (int i = 0; i < n; i++) begin
      s.wr = 1'b1; s.first = (i == 0); s.addr = SA + 16'(i); s.data = SEED + 8'(i);
      s.delta = (i == 0) ? 1 : int'(GW) + 1;
      exp_start.push_back(s);
    end
    if (r && !(w && no_resp)) for (int i = 0; i < n; i++) begin
      s.wr = 1'b0; s.first = (!w && i == 0); s.addr = SA + 16'(i); s.data = 8'h00;
      s.delta = s.first ? 1 : ((i == 0) ? int'(GW) + 1 : int'(GR) + 1);
      exp_start.push_back(s);
      if (!no_resp) begin
        exp_vld.push_back(ret[i]);
        if (ret[i] != SEED + 8'(i)) cnt++;
      end
    end
    if (r) exp_mism = 8'(cnt);
    d.err = no_resp; d.mism = exp_mism; d.from_start = no_resp;
    d.delta = no_resp ? int'(TO) + 1 : (r ? int'(GR) + 1 : int'(GW) + 1);
    exp_done.push_back(d);
  endtask

  task automatic issue(input bit w, input bit r);
    model(w, r);
    @(posedge clk); #1;
    wr_req = w; rd_req = r; req_cyc = cyc;
    @(posedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic pulse_busy_reqs();
    @(posedge clk); #1 wr_req = 1'b1; rd_req = 1'b1;
    @(posedge clk); #1 wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(posedge clk); n++; end
    chk("done_seen", 32'(done_cnt), 32'(target));
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("single_done", 32'(done_cnt), 32'(target));
  endtask

  task automatic set_resp(input int lo, input int hi, input bit rnd_data);
    for (int i = 0; i < NB; i++) begin
      wl[i]  = $urandom_range(hi, lo);
      rl[i]  = $urandom_range(hi, lo);
      ret[i] = (rnd_data && $urandom_range(1, 0) == 1) ? 8'($urandom) : SEED + 8'(i);
    end
  endtask

  initial begin
    int target = 0;
    int s0, n;
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    set_resp(5, 45, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_en", 32'({wr_en_o, rd_en_o, i2c_start_o, done_o}), 32'd0);
    chk("rst_addr_data", 32'({byte_addr_o, wr_data_o}), 32'd0);
    chk("rst_rd", 32'({rd_byte_o, rd_byte_vld_o}), 32'd0);
    chk("rst_status", 32'({mismatch_cnt_o, err_timeout_o}), 32'd0);
    chk("rst_addr_num", 32'(addr_num_o), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write burst, with requests arriving while busy.
    issue(1'b1, 1'b0);
    repeat (20) @(posedge clk);
    pulse_busy_reqs();
    target++; wait_done(target);

    // Clean read burst.
    ret = '{SEED, SEED + 8'd1, SEED + 8'd2};
    issue(1'b0, 1'b1);
    target++; wait_done(target);

    // Read burst with one corrupted byte.
    ret = '{SEED, 8'hFF, SEED + 8'd2};
    issue(1'b0, 1'b1);
    target++; wait_done(target);
    chk("mismatch_one", 32'(mismatch_cnt_o), 32'd1);

    // Simultaneous requests: writes then reads, one done.
    set_resp(3, 30, 1'b1);
    issue(1'b1, 1'b1);
    target++; wait_done(target);

    // End arriving in the very cycle the timeout would expire.
    wl = '{int'(TO), int'(TO), int'(TO)};
    issue(1'b1, 1'b0);
    target++; wait_done(target);
    chk("boundary_no_err", 32'(err_timeout_o), 32'd0);

    // Timeout, sticky flag, then cleared by the next request.
    no_resp = 1'b1;
    issue(1'b1, 1'b0);
    target++; wait_done(target);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", 32'(err_timeout_o), 32'd1);
    no_resp = 1'b0;
    set_resp(2, 20, 1'b0);
    issue(1'b0, 1'b1);
    @(negedge clk);
    chk("err_cleared", 32'(err_timeout_o), 32'd0);
    target++; wait_done(target);

    // Reset mid-transaction plus ignored requests.
    no_resp = 1'b1;
    issue(1'b1, 1'b0);
    s0 = start_cnt - 1;
    n = 0;
    while (start_cnt == s0 && n < 100) begin @(posedge clk); n++; end
    repeat (10) @(posedge clk);
    pulse_busy_reqs();
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_wr_en", 32'(wr_en_o), 32'd1);
    @(negedge clk);
    chk("abort_en", 32'({wr_en_o, rd_en_o, i2c_start_o}), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_addr", 32'(byte_addr_o), 32'd0);
    exp_done.delete();
    exp_mism = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    no_resp = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", 32'(busy_o), 32'd0);

    // Randomized bursts.
    for (int it = 0; it < 6; it++) begin
      int k = $urandom_range(2, 0);
      set_resp(1, int'(TO), 1'b1);
      issue(k != 1, k != 0);
      target++; wait_done(target);
    end

    chk("start_q_empty", 32'(exp_start.size()), 32'd0);
    chk("vld_q_empty", 32'(exp_vld.size()), 32'd0);
    chk("done_q_empty", 32'(exp_done.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
